ps2_rx_fifo: RTL and testbench

//   PS/2 device-to-host receiver feeding the wiggly_ic_1 keyboard/mouse decode logic.
//   - Samples the asynchronous PS/2 clock and data pad inputs (io_in[8]/[9] for the keyboard).
//   - Deglitches the PS/2 clock and checks each 11-bit frame: start, 8 data bits LSB-first,
//     odd parity, stop.
//   - Queues good bytes in a small FIFO drained with a valid/ready handshake.
//   - Reports framing, parity and overflow errors as one-cycle pulses.

---
 rtl/ps2_rx_fifo.sv | 124 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with clock deglitch, frame check, byte FIFO and error pulses; ports: clk, rst_n, ps2_clk, ps2_data, rx_data/rx_valid/rx_ready, busy, frame_err, parity_err, overflow
module ps2_rx_fifo #(
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int FILT_LEN = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic c1, c2, d1, d2, filt, filt_q, sample, push, pop, wr, full;
  logic [FW-1:0] fcnt;
  logic [2:0] bcnt;
  logic [7:0] sh, head_n;
  logic par;
  logic [TW-1:0] tcnt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp, rp_nx;
  logic [CW-1:0] count, cnt_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {c1, c2, d1, d2, filt, filt_q} <= '1;
      fcnt <= '0;
    end else begin
      c1 <= ps2_clk;
      c2 <= c1;
      d1 <= ps2_data;
      d2 <= d1;
      filt_q <= filt;
      if (c2 == filt) fcnt <= '0;
      else if (fcnt == FW'(FILT_LEN - 1)) begin
        filt <= c2;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  // one-cycle event on each filtered falling edge of the PS/2 clock
  assign sample = filt_q & ~filt;
  assign push = sample && state == STOP && d2 && ^{sh, par};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      bcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tcnt <= '0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      tcnt <= (sample || state == IDLE) ? '0 : tcnt + 1'b1;
      if (sample) begin
        case (state)
          IDLE: if (!d2) begin
            state <= DATA;
            busy <= 1'b1;
            bcnt <= '0;
          end else frame_err <= 1'b1;
          DATA: begin
            sh <= {d2, sh[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= d2;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            busy <= 1'b0;
            if (!d2) frame_err <= 1'b1;
            else if (!(^{sh, par})) parity_err <= 1'b1;
          end
        endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
        busy <= 1'b0;
        frame_err <= 1'b1;
      end
    end
  end
  assign rx_valid = count != '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign pop = rx_valid & rx_ready;
  assign wr = push & (~full | pop);
  assign rp_nx = rp + AW'(1);
  // rx_data is a register, so look ahead to whichever byte becomes the head next cycle
  always_comb begin
    cnt_n = count + CW'(wr) - CW'(pop);
    head_n = (count == '0 || (pop && count == CW'(1))) ? sh : (pop ? mem[rp_nx] : mem[rp]);
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= sh;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      rx_data <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp_nx;
      count <= cnt_n;
      if (cnt_n != '0) rx_data <= head_n;
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo driving PS/2 frames and checking bytes, errors and FIFO behaviour
module tb_ps2_rx_fifo;
  localparam int H = 50;
  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, rx_ready = 1;
  logic [7:0] rx_data;
  logic rx_valid, busy, frame_err, parity_err, overflow;
  int total = 0, bad = 0;
  int fe = 0, pe = 0, ov = 0, wide = 0;
  logic fe_q = 0, pe_q = 0, ov_q = 0;
  logic [7:0] q[$];
  ps2_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err === 1'b1) fe++;
      if (parity_err === 1'b1) pe++;
      if (overflow === 1'b1) ov++;
      if ((frame_err & fe_q) | (parity_err & pe_q) | (overflow & ov_q)) wide++;
      if (rx_valid === 1'b1 && rx_ready) q.push_back(rx_data);
    end
    fe_q <= frame_err;
    pe_q <= parity_err;
    ov_q <= overflow;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [10:0] fr(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction
  function automatic logic [10:0] good(input logic [7:0] b);
    return fr(b, ~^b, 1'b1);
  endfunction
  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      tick(H);
      ps2_clk = 0;
      tick(H);
      ps2_clk = 1;
    end
    tick(H);
  endtask
  task automatic glitch(input int n);
    ps2_clk = 0;
    tick(n);
    ps2_clk = 1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    tick(4);
    total++;
    if ({rx_data, rx_valid, busy, frame_err, parity_err, overflow} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h expected 0", {rx_data, rx_valid, busy, frame_err, parity_err, overflow});
    end
    rst_n = 1;
    tick(10);
  endtask
  task automatic test_good_frame;
    int fe0 = fe, pe0 = pe;
    q.delete();
    send_bits(good(8'h1C), 0, 4);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL good_busy_mid: got %b expected 1", busy); end
    send_bits(good(8'h1C), 5, 10);
    total++;
    if (q.size() != 1) begin bad++; $display("FAIL good_count: got %0d expected 1", q.size()); end
    else if (q[0] !== 8'h1C) begin bad++; $display("FAIL good_data: got %h expected 1c", q[0]); end
    total++;
    if (fe != fe0 || pe != pe0) begin bad++; $display("FAIL good_errs: got fe=%0d pe=%0d expected none", fe - fe0, pe - pe0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_end: got %b expected 0", busy); end
  endtask
  task automatic test_errors;
    int fe0 = fe, pe0 = pe;
    q.delete();
    send_bits(fr(8'h1C, 1'b1, 1'b1), 0, 10);
    total++;
    if (pe - pe0 != 1 || fe != fe0) begin bad++; $display("FAIL parity_pulse: got pe=%0d fe=%0d expected pe=1 fe=0", pe - pe0, fe - fe0); end
    total++;
    if (q.size() != 0 || rx_valid !== 1'b0) begin bad++; $display("FAIL parity_discard: got %0d bytes expected 0", q.size()); end
    send_bits(fr(8'h1C, 1'b0, 1'b0), 0, 10);
    tick(3 * H);
    total++;
    if (fe - fe0 != 1 || pe - pe0 != 1) begin bad++; $display("FAIL stop_pulse: got fe=%0d pe=%0d expected fe=1 pe=1", fe - fe0, pe - pe0); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL stop_discard: got %0d bytes expected 0", q.size()); end
  endtask
  task automatic test_timeout;
    int fe0 = fe;
    q.delete();
    send_bits(good(8'h55), 0, 3);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_pre: got %b expected 1", busy); end
    tick(2510);
    total++;
    if (fe - fe0 != 1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_abort: got fe=%0d busy=%b expected fe=1 busy=0", fe - fe0, busy); end
    send_bits(good(8'hF0), 0, 10);
    total++;
    if (q.size() != 1) begin bad++; $display("FAIL timeout_next_count: got %0d expected 1", q.size()); end
    else if (q[0] !== 8'hF0) begin bad++; $display("FAIL timeout_next_data: got %h expected f0", q[0]); end
  endtask
  task automatic test_overflow;
    int ov0 = ov;
    q.delete();
    rx_ready = 0;
    for (int b = 1; b <= 5; b++) send_bits(good(8'(b)), 0, 10);
    chk("ovf_pulse", ov - ov0, 1);
    chk("ovf_valid", {31'd0, rx_valid}, 1);
    chk("ovf_head_held", {24'd0, rx_data}, 32'h01);
    rx_ready = 1;
    tick(10);
    chk("ovf_pop_count", q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_pop%0d", i), (q.size() > i) ? {24'd0, q[i]} : 32'hffff, 32'(i + 1));
    chk("ovf_empty", {31'd0, rx_valid}, 0);
  endtask
  task automatic test_glitch;
    int fe0 = fe;
    q.delete();
    glitch(1);
    tick(20);
    glitch(2);
    tick(20);
    chk("glitch_idle_busy", {31'd0, busy}, 0);
    chk("glitch_idle_err", fe - fe0, 0);
    send_bits(good(8'h3A), 0, 3);
    glitch(2);
    tick(20);
    glitch(1);
    tick(20);
    chk("glitch_mid_busy", {31'd0, busy}, 1);
    send_bits(good(8'h3A), 4, 10);
    chk("glitch_count", q.size(), 1);
    chk("glitch_data", (q.size() > 0) ? {24'd0, q[0]} : 32'hffff, 32'h3A);
    chk("glitch_err", fe - fe0, 0);
  endtask
  task automatic test_reset_mid;
    rx_ready = 0;
    send_bits(good(8'h11), 0, 10);
    send_bits(good(8'h22), 0, 10);
    chk("rmid_queued", {31'd0, rx_valid}, 1);
    send_bits(good(8'h55), 0, 5);
    rst_n = 0;
    tick(1);
    rst_n = 1;
    total++;
    if ({rx_data, rx_valid, busy, frame_err, parity_err, overflow} !== 13'd0) begin
      bad++;
      $display("FAIL rmid_outputs: got %0h expected 0", {rx_data, rx_valid, busy, frame_err, parity_err, overflow});
    end
    tick(20);
    q.delete();
    rx_ready = 1;
    send_bits(good(8'hA5), 0, 10);
    chk("rmid_count", q.size(), 1);
    chk("rmid_data", (q.size() > 0) ? {24'd0, q[0]} : 32'hffff, 32'hA5);
  endtask
  initial begin
    test_reset;
    test_good_frame;
    test_errors;
    test_timeout;
    test_overflow;
    test_glitch;
    test_reset_mid;
    chk("pulse_width", wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
